// File: rtl/dispatch_queue.sv
// In-order dispatch queue: circular buffer of decoded packets that releases up to DISP_W per cycle,
// gated by ROB and per-FU RS credits. Define DISPATCH_QUEUE_BYPASS_EN for same-cycle slot-0 bypass.
module dispatch_queue #(
    parameter int DEPTH  = 8,
    parameter int DISP_W = 2,
    parameter int NUM_FU = 4,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 4,
    localparam int FU_W  = $clog2(NUM_FU),
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_pack,
    input  logic [FU_W-1:0]          in_fu,
    input  logic [NUM_FU*CNT_W-1:0]  rs_free,
    input  logic [CNT_W-1:0]         rob_free,
    output logic [DISP_W-1:0]        out_valid,
    output logic [DISP_W*DATA_W-1:0] out_pack,
    output logic [DISP_W*FU_W-1:0]   out_fu,
    output logic [NUM_FU-1:0]        rs_load,
    output logic [OCC_W-1:0]         count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [FU_W-1:0]   fu_q  [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] count_q, count_d;

    logic [PTR_W-1:0]  slot_idx   [DISP_W];
    logic [DATA_W-1:0] slot_pack  [DISP_W];
    logic [FU_W-1:0]   slot_fu    [DISP_W];
    logic [DISP_W-1:0] slot_avail;

    logic             bypass;
    logic             run;
    int               same_fu;
    logic [OCC_W-1:0] n_disp;
    logic [OCC_W-1:0] n_pop;
    logic             enq;
    logic             enq_wr;

    assign in_ready = (count_q != OCC_W'(DEPTH)) && !flush;
    assign count    = count_q;

    // Candidate entries for each slot, oldest first.
    always_comb begin
        bypass     = 1'b0;
        slot_avail = '0;
`ifdef DISPATCH_QUEUE_BYPASS_EN
        bypass = (count_q == '0) && in_valid && !flush;
`endif
        for (int k = 0; k < DISP_W; k++) begin
            slot_idx[k]   = head_q + PTR_W'(k);
            slot_pack[k]  = mem_q[slot_idx[k]];
            slot_fu[k]    = fu_q[slot_idx[k]];
            slot_avail[k] = (OCC_W'(k) < count_q);
        end
        if (bypass) begin
            slot_pack[0]  = in_pack;
            slot_fu[0]    = in_fu;
            slot_avail[0] = 1'b1;
        end
    end

    // Grant a contiguous run of slots; the first blocked slot stops all younger ones.
    always_comb begin
        out_valid = '0;
        out_pack  = '0;
        out_fu    = '0;
        rs_load   = '0;
        n_disp    = '0;
        run       = !flush;
        same_fu   = 0;
        for (int k = 0; k < DISP_W; k++) begin
            same_fu = 0;
            for (int j = 0; j <= k; j++) begin
                if (slot_fu[j] == slot_fu[k]) begin
                    same_fu = same_fu + 1;
                end
            end
            if (run && slot_avail[k] && (k < int'(rob_free))
                && (same_fu <= int'(rs_free[int'(slot_fu[k])*CNT_W +: CNT_W]))) begin
                out_valid[k]                 = 1'b1;
                out_pack[k*DATA_W +: DATA_W] = slot_pack[k];
                out_fu[k*FU_W +: FU_W]       = slot_fu[k];
                rs_load[slot_fu[k]]          = 1'b1;
                n_disp                       = n_disp + OCC_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    always_comb begin
        enq     = in_valid && in_ready;
        // A bypassed packet that dispatches never touches storage.
        enq_wr  = enq && !(bypass && out_valid[0]);
        n_pop   = bypass ? '0 : n_disp;
        head_d  = head_q + n_pop[PTR_W-1:0];
        tail_d  = tail_q + PTR_W'(enq_wr);
        count_d = count_q + OCC_W'(enq_wr) - n_pop;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_wr) begin
            mem_q[tail_q] <= in_pack;
            fu_q[tail_q]  <= in_fu;
        end
    end

endmodule

// File: tb/tb_dispatch_queue.sv
// Bench for dispatch_queue: directed test-plan sequences with literal checks, then randomized traffic
// compared every cycle against a queue-based reference model.
module tb_dispatch_queue;
    localparam int DEPTH  = 8;
    localparam int DISP_W = 2;
    localparam int NUM_FU = 4;
    localparam int DATA_W = 128;
    localparam int CNT_W  = 4;
    localparam int FU_W   = 2;
    localparam int OCC_W  = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_pack;
    logic [FU_W-1:0]          in_fu;
    logic [NUM_FU*CNT_W-1:0]  rs_free;
    logic [CNT_W-1:0]         rob_free;
    logic [DISP_W-1:0]        out_valid;
    logic [DISP_W*DATA_W-1:0] out_pack;
    logic [DISP_W*FU_W-1:0]   out_fu;
    logic [NUM_FU-1:0]        rs_load;
    logic [OCC_W-1:0]         count;

    dispatch_queue #(.DEPTH(DEPTH), .DISP_W(DISP_W), .NUM_FU(NUM_FU), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pack(in_pack), .in_fu(in_fu), .rs_free(rs_free), .rob_free(rob_free),
        .out_valid(out_valid), .out_pack(out_pack), .out_fu(out_fu), .rs_load(rs_load), .count(count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] mq_pack [$];
    int                mq_fu   [$];

    logic [DISP_W-1:0] obs_valid;
    logic [OCC_W-1:0]  obs_count;
    logic              obs_ready;
    logic [NUM_FU-1:0] obs_load;
    logic [FU_W-1:0]   obs_fu0;

    localparam logic [NUM_FU*CNT_W-1:0] RF4 = {NUM_FU{4'd4}};
    localparam logic [NUM_FU*CNT_W-1:0] RF0 = '0;

    function automatic logic [NUM_FU*CNT_W-1:0] rf_one(input int f, input int n);
        logic [NUM_FU*CNT_W-1:0] r;
        r = '0;
        r[f*CNT_W +: CNT_W] = CNT_W'(n);
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare combinational outputs to the model, advance model to the next edge.
    task automatic cyc(input logic iv, input logic fl, input int fu, input logic [NUM_FU*CNT_W-1:0] rf,
                       input int rb);
        int                size;
        int                used [NUM_FU];
        int                n;
        logic              byp;
        logic [DISP_W-1:0] ev;
        logic [NUM_FU-1:0] el;
        logic              avail [DISP_W];
        int                cfu   [DISP_W];
        logic [DATA_W-1:0] cpk   [DISP_W];
        in_valid = iv;
        flush    = fl;
        in_fu    = FU_W'(fu);
        in_pack  = {$urandom, $urandom, $urandom, $urandom};
        rs_free  = rf;
        rob_free = CNT_W'(rb);
        #3;
        size = mq_fu.size();
        byp  = 1'b0;
`ifdef DISPATCH_QUEUE_BYPASS_EN
        byp = (size == 0) && iv && !fl;
`endif
        for (int f = 0; f < NUM_FU; f++) used[f] = 0;
        for (int k = 0; k < DISP_W; k++) begin
            avail[k] = (k < size);
            cfu[k]   = (k < size) ? mq_fu[k] : 0;
            cpk[k]   = (k < size) ? mq_pack[k] : '0;
        end
        if (byp) begin
            avail[0] = 1'b1;
            cfu[0]   = fu;
            cpk[0]   = in_pack;
        end
        n  = 0;
        ev = '0;
        el = '0;
        if (!fl) begin
            for (int k = 0; k < DISP_W; k++) begin
                if (!avail[k] || k >= rb) break;
                used[cfu[k]]++;
                if (used[cfu[k]] > int'(rf[cfu[k]*CNT_W +: CNT_W])) break;
                ev[k]      = 1'b1;
                el[cfu[k]] = 1'b1;
                n++;
            end
        end
        chk("out_valid", 128'(out_valid), 128'(ev));
        chk("rs_load", 128'(rs_load), 128'(el));
        chk("count", 128'(count), 128'(size));
        chk("in_ready", 128'(in_ready), 128'((size != DEPTH) && !fl));
        for (int k = 0; k < DISP_W; k++) begin
            if (ev[k]) begin
                chk("out_pack", out_pack[k*DATA_W +: DATA_W], cpk[k]);
                chk("out_fu", 128'(out_fu[k*FU_W +: FU_W]), 128'(cfu[k]));
            end
        end
        obs_valid = out_valid;
        obs_count = count;
        obs_ready = in_ready;
        obs_load  = rs_load;
        obs_fu0   = out_fu[FU_W-1:0];
        if (fl) begin
            mq_pack.delete();
            mq_fu.delete();
        end else begin
            if (!byp) begin
                for (int k = 0; k < n; k++) begin
                    void'(mq_pack.pop_front());
                    void'(mq_fu.pop_front());
                end
            end
            if (iv && size < DEPTH && !(byp && n > 0)) begin
                mq_pack.push_back(in_pack);
                mq_fu.push_back(fu);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pack = '0; in_fu = '0;
        rs_free = RF4; rob_free = 4'd8;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #2;

        // Reset state.
        cyc(0, 0, 0, RF4, 8);
        chk("rst_count", 128'(obs_count), 128'd0);
        chk("rst_valid", 128'(obs_valid), 128'd0);
        chk("rst_ready", 128'(obs_ready), 128'd1);
        chk("rst_load", 128'(obs_load), 128'd0);

        // A(fu0), B(fu1): one-cycle latency, count never above 1.
        cyc(1, 0, 0, RF4, 8);
`ifndef DISPATCH_QUEUE_BYPASS_EN
        chk("a_enq_valid", 128'(obs_valid), 128'd0);
`endif
        cyc(1, 0, 1, RF4, 8);
`ifndef DISPATCH_QUEUE_BYPASS_EN
        chk("a_disp_valid", 128'(obs_valid), 128'b01);
        chk("a_disp_fu", 128'(obs_fu0), 128'd0);
        chk("a_disp_load", 128'(obs_load), 128'b0001);
        chk("a_disp_count", 128'(obs_count), 128'd1);
`endif
        cyc(0, 0, 0, RF4, 8);
`ifndef DISPATCH_QUEUE_BYPASS_EN
        chk("b_disp_load", 128'(obs_load), 128'b0010);
        chk("b_disp_count", 128'(obs_count), 128'd1);
`endif
        cyc(0, 0, 0, RF4, 8);
        chk("ab_drained", 128'(obs_count), 128'd0);

        // Fill to DEPTH with fu2, then release one per cycle.
        repeat (8) cyc(1, 0, 2, RF0, 8);
        cyc(1, 0, 2, rf_one(2, 1), 8);
        chk("full_count", 128'(obs_count), 128'd8);
        chk("full_ready", 128'(obs_ready), 128'd0);
        chk("full_valid", 128'(obs_valid), 128'b01);
        cyc(0, 0, 2, RF0, 8);
        chk("after_full_count", 128'(obs_count), 128'd7);
        chk("after_full_ready", 128'(obs_ready), 128'd1);
        repeat (6) cyc(0, 0, 0, rf_one(2, 1), 8);
        cyc(0, 0, 0, RF4, 8);
        chk("drain_count", 128'(obs_count), 128'd1);
        cyc(0, 0, 0, RF4, 8);

        // Same-FU pair limited by RS credit.
        repeat (2) cyc(1, 0, 0, RF0, 8);
        cyc(0, 0, 0, rf_one(0, 1), 8);
        chk("rs1_valid", 128'(obs_valid), 128'b01);
        chk("rs1_count", 128'(obs_count), 128'd2);
        cyc(0, 0, 0, rf_one(0, 2), 8);
        chk("rs2_valid", 128'(obs_valid), 128'b01);
        chk("rs2_count", 128'(obs_count), 128'd1);
        cyc(0, 0, 0, RF4, 8);
        chk("rs_drained", 128'(obs_count), 128'd0);

        // ROB credit limits.
        repeat (3) cyc(1, 0, 1, RF0, 8);
        cyc(0, 0, 0, RF4, 1);
        chk("rob1_valid", 128'(obs_valid), 128'b01);
        chk("rob1_count", 128'(obs_count), 128'd3);
        cyc(0, 0, 0, RF4, 0);
        chk("rob0_valid", 128'(obs_valid), 128'b00);
        chk("rob0_count", 128'(obs_count), 128'd2);
        cyc(0, 0, 0, RF4, 0);
        chk("rob0_hold", 128'(obs_count), 128'd2);

        // Flush with 5 entries and a pending packet.
        repeat (3) cyc(1, 0, 3, RF0, 8);
        cyc(1, 1, 0, RF4, 8);
        chk("flush_count", 128'(obs_count), 128'd5);
        chk("flush_valid", 128'(obs_valid), 128'd0);
        chk("flush_ready", 128'(obs_ready), 128'd0);
        cyc(0, 0, 0, RF4, 8);
        chk("post_flush_count", 128'(obs_count), 128'd0);
        chk("post_flush_valid", 128'(obs_valid), 128'd0);

`ifdef DISPATCH_QUEUE_BYPASS_EN
        cyc(1, 0, 3, rf_one(3, 2), 8);
        chk("byp_valid", 128'(obs_valid), 128'b01);
        cyc(0, 0, 0, RF0, 8);
        chk("byp_count", 128'(obs_count), 128'd0);
        cyc(1, 0, 3, RF0, 8);
        chk("byp_block_valid", 128'(obs_valid), 128'd0);
        cyc(0, 0, 0, RF0, 8);
        chk("byp_block_count", 128'(obs_count), 128'd1);
        cyc(0, 0, 0, RF4, 8);
`endif

        // Randomized traffic, with one asynchronous reset mid-stream.
        for (int i = 0; i < 3000; i++) begin
            logic [NUM_FU*CNT_W-1:0] rf;
            for (int f = 0; f < NUM_FU; f++) rf[f*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 3));
            if (i == 1500) begin
                reset = 1'b1;
                #2;
                chk("async_rst_count", 128'(count), 128'd0);
                chk("async_rst_valid", 128'(out_valid), 128'd0);
                mq_pack.delete();
                mq_fu.delete();
                @(posedge clk);
                #1 reset = 1'b0;
            end
            cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0), $urandom_range(0, NUM_FU-1), rf,
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : $urandom_range(0, 8));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dispatch_queue.md
# dispatch_queue

Parametrised in-order instruction queue and multi-issue dispatch stage between the decoder and the reservation stations/ROB. It buffers up to DEPTH decoded packets and releases up to DISP_W packets per cycle, in program order. Each cycle's release is limited by free ROB entries and by per-FU reservation-station free-slot counts, so decoder stalls are absorbed by the queue instead of propagating back every cycle. A flush input discards all buffered work on mispredict.

## Interface
- DEPTH, 8: queue entries; power of two, ≥ DISP_W.
- DISP_W, 2: maximum packets dispatched per cycle.
- NUM_FU, 4: number of FU classes / reservation stations.
- DATA_W, 128: opaque decoded-packet payload width.
- CNT_W, 4: width of the rs_free and rob_free counts.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous discard of every queued entry.
- in_valid  in  1  decoder presents a packet.
- in_ready  out  1  queue accepts the packet this cycle; `in_valid & in_ready` = enqueue.
- in_pack  in  DATA_W  packet payload.
- in_fu  in  $clog2(NUM_FU)  target FU class of the packet.
- rs_free  in  NUM_FU×CNT_W  free slots per RS; sampled this cycle.
- rob_free  in  CNT_W  free ROB entries this cycle.
- out_valid  out  DISP_W  slot k carries a dispatched packet this cycle.
- out_pack  out  DISP_W×DATA_W  payload per slot; slot 0 is oldest.
- out_fu  out  DISP_W×$clog2(NUM_FU)  FU class per slot.
- rs_load  out  NUM_FU  bit f is set if any valid slot targets FU f.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage is a circular buffer with head, tail and count registers. Pointers wrap modulo DEPTH.
- Enqueue:
  - At most one packet per cycle.
  - in_ready = (count != DEPTH) & ~flush.
  - in_ready is derived from registered count only; it never depends on same-cycle dispatch. When full, push-while-pop is refused.
- Dispatch (combinational from head state):
  - Slot k is valid iff all of the following hold:
    - entry head+k exists (k < count);
    - slot k-1 is valid;
    - k < rob_free;
    - (number of slots 0..k targeting out_fu[k]) ≤ rs_free[out_fu[k]].
  - Dispatch stops at the first blocked slot, so out_valid is always a contiguous low-order run (thermometer).
  - Valid slots are consumed unconditionally. Downstream RS and ROB must accept every valid slot; there is no per-slot ready.
- Update at clock edge:
  - head += popcount(out_valid);
  - tail += enqueue;
  - count += enqueue − popcount(out_valid).
- Flush: head = tail = count = 0. out_valid is forced to 0 and in_ready to 0 in the flush cycle. flush has priority over enqueue and dispatch.
- Reset values:
  - count = 0, head = 0, tail = 0;
  - out_valid = 0, rs_load = 0;
  - in_ready = 1 once reset deasserts.
  - Payload storage is not cleared.
- Reset mid-operation discards all entries immediately (asynchronous).

## Timing
- Without bypass: a packet enqueued in cycle t can dispatch no earlier than cycle t+1.
- Dispatch outputs are combinational from the registered queue plus this cycle's rs_free and rob_free. There is no extra pipeline stage.
- Throughput: 1 enqueue per cycle, up to DISP_W dispatches per cycle.
- Boundaries:
  - count=0: out_valid=0 (unless bypass applies).
  - count=DEPTH: in_ready=0, dispatch continues.
  - rob_free=0 or rs_free of the head's FU is 0: nothing dispatches, because order is preserved.
  - Wrap-around of head/tail across DEPTH-1→0 is seamless.

## Configuration
- DISPATCH_QUEUE_BYPASS_EN defined:
  - When count==0, in_valid=1 and flush=0, slot 0 presents in_pack/in_fu in the same cycle, under the normal slot-0 rules.
  - If slot 0 dispatches, the packet is not written into the queue and count stays 0. Otherwise it is enqueued normally.
  - Only slot 0 bypasses.
- Not defined: no bypass. Minimum queue latency is 1 cycle.

## Test plan
- Reset, then enqueue A(fu0), B(fu1) on consecutive cycles with rs_free all 4 and rob_free 8 -> A appears in slot 0 one cycle after its enqueue. count never exceeds 1. rs_load=0001 then 0010.
- Fill 8 entries all fu2 with rs_free[2]=1 -> exactly one dispatch per cycle and out_valid=01. in_ready=0 at count=8 and returns to 1 the cycle after count drops to 7.
- Queue holds fu0, fu0 with rs_free[0]=1 and rob_free=8 -> only slot 0 is valid. Next cycle with rs_free[0]=2, the remaining entry dispatches.
- Queue holds 3 entries with rob_free=1 -> out_valid=01. With rob_free=0 -> out_valid=00 and count is unchanged.
- Queue holds 5 entries and in_valid=1, then assert flush -> that cycle out_valid=0 and in_ready=0. Next cycle count=0 and head=tail.
- With DISPATCH_QUEUE_BYPASS_EN, empty queue, in_valid with fu3, rs_free[3]=2 -> out_valid=01 in the same cycle and count stays 0. Repeat with rs_free[3]=0 -> count becomes 1.
